// File: rtl/trng_pkg.sv
// Shared defaults, corrector state type and requester indices for the TRNG byte scheduler.
package trng_pkg;

    localparam int SAMPLE_DIV_DEF = 4;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int REP_LIMIT_DEF  = 32;

    typedef enum logic {
        VN_FIRST  = 1'b0,
        VN_SECOND = 1'b1
    } vn_state_e;

    localparam logic REQ_VGA  = 1'b0;
    localparam logic REQ_UART = 1'b1;

endpackage

// File: rtl/von_neumann_debias.sv
// Von Neumann corrector: pairs strobed samples, emits the first sample of a 01/10 pair.
module von_neumann_debias
    import trng_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    input  logic sample,
    output logic bit_valid,
    output logic corr_bit
);

    vn_state_e state_r;
    vn_state_e state_next_s;
    logic      first_r;

    // Corrector state and first-of-pair latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= VN_FIRST;
            first_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (strobe && (state_r == VN_FIRST)) begin
                first_r <= sample;
            end
        end
    end

    // Pair evaluation: 10 yields 1, 01 yields 0, equal pairs are dropped
    always_comb begin
        state_next_s = state_r;
        bit_valid    = 1'b0;
        corr_bit     = first_r;
        case (state_r)
            VN_FIRST: begin
                if (strobe) begin
                    state_next_s = VN_SECOND;
                end else begin
                    state_next_s = VN_FIRST;
                end
            end
            VN_SECOND: begin
                if (strobe) begin
                    state_next_s = VN_FIRST;
                    bit_valid    = (sample != first_r);
                end else begin
                    state_next_s = VN_SECOND;
                end
            end
            default: begin
                state_next_s = VN_FIRST;
            end
        endcase
    end

endmodule

// File: rtl/trng_byte_scheduler.sv
// Ring-oscillator entropy harvester: sync, strobe, debias, byte FIFO, two-way round-robin.
// Optional repetition-count health test enabled by defining TRNG_HEALTH_EN.
module trng_byte_scheduler
    import trng_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int REP_LIMIT  = REP_LIMIT_DEF
) (
    input  logic                                clk_100mhz,
    input  logic                                reset,
    input  logic                                raw_bit,
    input  logic [1:0]                          req,
    output logic [1:0]                          grant,
    output logic [7:0]                          rnd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
    output logic                                health_fail
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic             sync1_r;
    logic             sync2_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic             strobe_s;
    logic             vn_valid_s;
    logic             vn_bit_s;

    logic [7:0]       shift_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       hold_r;
    logic             hold_valid_r;
    logic [7:0]       done_byte_s;
    logic             accept_bit_s;
    logic             byte_done_s;
    logic             push_s;
    logic [7:0]       push_data_s;
    logic             full_s;
    logic             push_ok_s;
    logic             health_block_s;

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             pop_s;
    logic             winner_s;
    logic             last_r;
    logic [1:0]       grant_r;
    logic [7:0]       rnd_data_r;

    // Two-flop synchronizer; only sync2_r is ever sampled
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw_bit;
            sync2_r <= sync1_r;
        end
    end

    // Free-running sample divider
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            div_cnt_r <= '0;
        end else if (strobe_s) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    assign strobe_s = (div_cnt_r == DIV_W'(SAMPLE_DIV - 1));

    von_neumann_debias u_debias (
        .clk       (clk_100mhz),
        .reset     (reset),
        .strobe    (strobe_s),
        .sample    (sync2_r),
        .bit_valid (vn_valid_s),
        .corr_bit  (vn_bit_s)
    );

    assign full_s    = (level_r == LVL_W'(FIFO_DEPTH));
    assign push_ok_s = !full_s && !health_block_s;

    // Byte assembly; a held byte has priority and blocks new corrected bits
    always_comb begin
        accept_bit_s = 1'b0;
        byte_done_s  = 1'b0;
        push_s       = 1'b0;
        push_data_s  = hold_r;
        done_byte_s  = {shift_r[6:0], vn_bit_s};
        if (hold_valid_r) begin
            push_s      = push_ok_s;
            push_data_s = hold_r;
        end else if (vn_valid_s) begin
            accept_bit_s = 1'b1;
            if (bit_cnt_r == 3'd7) begin
                byte_done_s = 1'b1;
                push_s      = push_ok_s;
                push_data_s = done_byte_s;
            end else begin
                byte_done_s = 1'b0;
            end
        end else begin
            accept_bit_s = 1'b0;
        end
    end

    // Partial byte shift register and held-byte buffer
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            shift_r      <= 8'h00;
            bit_cnt_r    <= 3'd0;
            hold_r       <= 8'h00;
            hold_valid_r <= 1'b0;
        end else if (hold_valid_r) begin
            if (push_ok_s) begin
                hold_valid_r <= 1'b0;
            end
        end else if (accept_bit_s) begin
            shift_r   <= done_byte_s;
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (byte_done_s && !push_ok_s) begin
                hold_r       <= done_byte_s;
                hold_valid_r <= 1'b1;
            end
        end
    end

    // Winner selection: lone requester wins, otherwise whoever was not served last
    always_comb begin
        pop_s = (req != 2'b00) && (level_r != LVL_W'(0));
        case (req)
            2'b01:   winner_s = REQ_VGA;
            2'b10:   winner_s = REQ_UART;
            2'b11:   winner_s = ~last_r;
            default: winner_s = last_r;
        endcase
    end

    // Registered grant, data and round-robin pointer
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            grant_r    <= 2'b00;
            rnd_data_r <= 8'h00;
            last_r     <= REQ_UART;
        end else if (pop_s) begin
            grant_r    <= (winner_s == REQ_UART) ? 2'b10 : 2'b01;
            rnd_data_r <= mem_r[rd_ptr_r];
            last_r     <= winner_s;
        end else begin
            grant_r    <= 2'b00;
        end
    end

    // Byte FIFO storage, pointers and occupancy
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

`ifdef TRNG_HEALTH_EN
    localparam int REP_W = $clog2(REP_LIMIT + 1);

    logic             prev_r;
    logic [REP_W-1:0] rep_cnt_r;
    logic [REP_W-1:0] rep_next_s;
    logic             health_r;

    // Repetition count: restart on a change, saturate at the limit
    always_comb begin
        rep_next_s = rep_cnt_r;
        if (sync2_r != prev_r) begin
            rep_next_s = REP_W'(1);
        end else if (rep_cnt_r < REP_W'(REP_LIMIT)) begin
            rep_next_s = rep_cnt_r + REP_W'(1);
        end else begin
            rep_next_s = rep_cnt_r;
        end
    end

    // Sticky health failure
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            prev_r    <= 1'b0;
            rep_cnt_r <= '0;
            health_r  <= 1'b0;
        end else if (strobe_s) begin
            prev_r    <= sync2_r;
            rep_cnt_r <= rep_next_s;
            if (rep_next_s == REP_W'(REP_LIMIT)) begin
                health_r <= 1'b1;
            end
        end
    end

    assign health_block_s = health_r;
    assign health_fail    = health_r;
`else
    assign health_block_s = 1'b0;
    assign health_fail    = 1'b0;
`endif

    assign grant      = grant_r;
    assign rnd_data   = rnd_data_r;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_trng_byte_scheduler.sv
// Scoreboard bench for trng_byte_scheduler; health checks follow TRNG_HEALTH_EN.
module tb_trng_byte_scheduler;

    logic       clk;
    logic       reset;
    logic       raw_bit;
    logic [1:0] req;
    logic [1:0] grant;
    logic [7:0] rnd_data;
    logic [2:0] fifo_level;
    logic       health_fail;

    typedef struct packed {
        logic [1:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   rise;

    trng_byte_scheduler dut (
        .clk_100mhz  (clk),
        .reset       (reset),
        .raw_bit     (raw_bit),
        .req         (req),
        .grant       (grant),
        .rnd_data    (rnd_data),
        .fifo_level  (fifo_level),
        .health_fail (health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_grant(input logic [1:0] g, input logic [7:0] d);
        sb_q.push_back('{g: g, d: d});
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset   = 1'b1;
        req     = 2'b00;
        raw_bit = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Each sample value is held for a full 4-clock strobe window
    task automatic drive_pair(input logic b1, input logic b2, input logic fire);
        for (int i = 0; i < 4; i++) begin
            raw_bit = b1;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            raw_bit = b2;
            if (fire && i == 3) req = 2'b01;
            tick();
        end
        if (fire) req = 2'b00;
    endtask

    task automatic drive_byte(input logic [7:0] v, input int discard_after, input logic fire_last);
        for (int i = 7; i >= 0; i--) begin
            drive_pair(v[i], ~v[i], fire_last && (i == 0));
            if (i == discard_after) begin
                drive_pair(1'b0, 1'b0, 1'b0);
                drive_pair(1'b1, 1'b1, 1'b0);
            end
        end
    endtask

    task automatic align8();
        while ((cyc % 8) != 0) tick();
    endtask

    // Monitor: every grant must match the oldest expected entry
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset === 1'b0 && grant !== 2'b00) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_grant: got grant=%b data=%h, expected no grant", grant, rnd_data);
            end else begin
                e = sb_q.pop_front();
                if (grant !== e.g || rnd_data !== e.d) begin
                    fails++;
                    $display("FAIL grant_data: got grant=%b data=%h, expected grant=%b data=%h",
                             grant, rnd_data, e.g, e.d);
                end
            end
        end
    end

    initial begin
        logic [2:0] drain_lvl [5];
        drain_lvl = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        reset   = 1'b1;
        raw_bit = 1'b0;
        req     = 2'b00;
        do_reset(3);

        check("reset_grant", grant, 2'b00);
        check("reset_rnd_data", rnd_data, 8'h00);
        check("reset_fifo_level", fifo_level, 3'd0);
        check("reset_health", health_fail, 1'b0);

        // Fill the FIFO; 0xA5 has dropped 00/11 pairs in the middle
        drive_byte(8'hFF, -1, 1'b0);
        check("level_after_ff", fifo_level, 3'd1);
        drive_byte(8'h00, -1, 1'b0);
        check("level_after_00", fifo_level, 3'd2);
        drive_byte(8'hA5, 4, 1'b0);
        check("level_after_a5", fifo_level, 3'd3);
        drive_byte(8'h3C, -1, 1'b0);
        check("level_after_3c", fifo_level, 3'd4);
        drive_byte(8'h5A, -1, 1'b0);
        check("level_full_held", fifo_level, 3'd4);

        // One grant: 4 -> 3, then the held byte refills to 4
        req = 2'b10;
        expect_grant(2'b10, 8'hFF);
        tick();
        req = 2'b00;
        check("level_after_pop", fifo_level, 3'd3);
        tick();
        check("level_held_refill", fifo_level, 3'd4);

        // Both requesting: last served was UART, so VGA goes first
        req = 2'b11;
        expect_grant(2'b01, 8'h00);
        expect_grant(2'b10, 8'hA5);
        expect_grant(2'b01, 8'h3C);
        expect_grant(2'b10, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("level_drain", fifo_level, {29'd0, drain_lvl[i]});
        end
        req = 2'b00;
        tick();
        check("drain_scoreboard_empty", sb_q.size(), 0);

        // Push of 0x2D and pop of 0x96 on the same edge
        align8();
        drive_byte(8'h96, -1, 1'b0);
        check("level_after_96", fifo_level, 3'd1);
        expect_grant(2'b01, 8'h96);
        drive_byte(8'h2D, -1, 1'b1);
        check("level_push_pop", fifo_level, 3'd1);

        // Reset with five bits assembled and one byte queued
        for (int i = 0; i < 5; i++) drive_pair(1'b1, 1'b0, 1'b0);
        do_reset(1);
        check("midreset_grant", grant, 2'b00);
        check("midreset_level", fifo_level, 3'd0);
        check("midreset_rnd_data", rnd_data, 8'h00);
        drive_byte(8'hC3, -1, 1'b0);
        check("level_after_c3", fifo_level, 3'd1);
        req = 2'b10;
        expect_grant(2'b10, 8'hC3);
        tick();
        req = 2'b00;
        check("level_after_c3_pop", fifo_level, 3'd0);

        // Stuck-at-1 source
        do_reset(2);
        raw_bit = 1'b1;
`ifdef TRNG_HEALTH_EN
        for (int i = 0; i < 200 && health_fail !== 1'b1; i++) tick();
        rise = (health_fail === 1'b1) ? cyc : -1;
        check("health_rise_cycle", rise, 128);
        for (int i = 0; i < 20; i++) drive_pair(1'b1, 1'b0, 1'b0);
        check("health_sticky", health_fail, 1'b1);
        check("health_blocks_push", fifo_level, 3'd0);
        do_reset(1);
        check("health_cleared", health_fail, 1'b0);
`else
        repeat (200) tick();
        check("health_disabled", health_fail, 1'b0);
        check("stuck_no_bytes", fifo_level, 3'd0);
`endif

        tick();
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trng_byte_scheduler.md
# trng_byte_scheduler

Harvests entropy from the free-running ring-oscillator XOR bit. It samples that bit on a fixed schedule, removes bias with a von Neumann corrector, and packs the corrected bits into bytes in a small FIFO. It then shares those bytes between two consumers (VGA snow renderer, UART/debug port) using round-robin arbitration. It sits between the ring-oscillator pair and all consumers of random data in the 100 MHz domain.

## Interface
- SAMPLE_DIV, 4: clocks between raw-bit samples (≥2).
- FIFO_DEPTH, 4: byte FIFO entries (power of two).
- REP_LIMIT, 32: identical consecutive samples that trip the health test.

- clk_100mhz  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- raw_bit  in  1  asynchronous ring-oscillator XOR output; never used unsynchronized.
- req  in  2  per-requester level request for one byte.
- grant  out  2  one-hot, one-cycle; rnd_data is valid for that requester in this cycle.
- rnd_data  out  8  random byte; held until the next grant.
- fifo_level  out  clog2(FIFO_DEPTH+1)  bytes currently stored.
- health_fail  out  1  sticky health-test failure.

One clock; reset is synchronous and active-high. Reset values: grant=0, rnd_data=0, fifo_level=0, health_fail=0.

## Operation
- **Synchronization:** raw_bit passes through a 2-FF synchronizer. Only the second FF output (the "sample source") is used.
- **Sample strobe:** a counter runs 0..SAMPLE_DIV-1, and the strobe fires when the counter is SAMPLE_DIV-1. The counter wraps and free-runs, and only reset clears it.
- **Von Neumann corrector:** two states, FIRST and SECOND.
  - FIRST: on strobe, latch the sample and go to SECOND.
  - SECOND: on strobe, compare with the latched sample. Pair 01 emits bit 0; pair 10 emits bit 1; 00 and 11 emit nothing. Return to FIRST in every case.
- **Byte assembly:** each emitted bit shifts in at bit 0 and existing bits move left, so the first bit ends up as the MSB.
  - After 8 bits the byte is complete, and it is pushed into the FIFO on the same edge if the FIFO is not full.
  - If the FIFO is full, the complete byte is held and the corrector's output bits are discarded until space frees. Strobes continue during this time.
- **Arbiter:**
  - A 1-bit pointer `last` (reset 1) records the last requester served.
  - In any cycle where the FIFO is non-empty and req≠0, the winner is chosen: the single requester if only one asks; otherwise the requester ≠ `last`.
  - Registered outputs on the next edge: grant[winner]=1, rnd_data=head byte, pop, last=winner.
  - A requester keeping req high is served again on later cycles, alternating with the other requester if both are asking.
- **FIFO:** push and pop in the same cycle are both performed and fifo_level is unchanged. A push into a full FIFO is never attempted (the byte is held instead). A pop from an empty FIFO never occurs.

## Timing
- Byte latency: from the strobe emitting the 8th bit, the byte is in the FIFO one edge later; fifo_level updates on that same edge.
- Grant latency: req sampled in cycle N with the FIFO non-empty gives grant in cycle N+1, for exactly one cycle.
- Throughput: at most one grant per cycle, and grants can occur on back-to-back cycles.
- A grant's pop decision uses the fifo_level registered before the edge. A byte pushed on the same edge is not grantable until the following cycle.
- Reset mid-operation takes effect on the next edge and clears all of the following: synchronizer, strobe counter, corrector state, partial byte, held byte, FIFO contents, `last`, grant, health state.

## Configuration
- TRNG_HEALTH_EN defined:
  - Repetition-count test on the sample source at each strobe. The counter resets to 1 when a sample differs from the previous one and saturates at REP_LIMIT.
  - Reaching REP_LIMIT sets health_fail, which stays set until reset.
  - While health_fail=1, FIFO pushes are blocked. Bytes already queued remain grantable.
- TRNG_HEALTH_EN undefined: no test logic; health_fail is tied to 0.

## Structure
- Package trng_pkg holds:
  - the default values of SAMPLE_DIV, FIFO_DEPTH and REP_LIMIT;
  - the enumerated corrector state type (VN_FIRST, VN_SECOND);
  - the requester index constants (REQ_VGA=0, REQ_UART=1).
- Natural sub-module: von_neumann_debias (strobe, sample in; bit_valid, bit out; carries the corrector FSM). Arbiter and FIFO stay in the top.

## Test plan
- raw_bit tracks the sampled pattern 1,0,1,0,… at each strobe (SAMPLE_DIV=4) -> every pair is 10 -> after 64 clocks fifo_level=1 with head 0xFF; pattern 0,1,… yields 0x00.
- raw_bit held 1 with TRNG_HEALTH_EN -> no bytes pushed; health_fail=1 after REP_LIMIT=32 strobes (plus synchronizer delay) and stays 1 until reset.
- FIFO preloaded with 4 bytes, req=2'b11 held -> grants 01,10,01,10 on consecutive cycles (last=1 after reset), FIFO order preserved, then grant=0.
- No requests while bytes accumulate -> fifo_level saturates at 4. The fifth byte is held; a single grant brings fifo_level 4->3->4 on the next edge.
- Push and pop on the same edge -> fifo_level unchanged; the popped byte is the old head.
- reset asserted mid-byte (5 bits assembled) -> next byte starts fresh from 8 new corrected bits; grant=0 and fifo_level=0 on the edge after reset.
